// File: rtl/guvm_mem_pkg.sv
// rtl/guvm_mem_pkg.sv - shared types and defaults for the instruction/data memory arbiter
// Contents: requester ID enum, arbiter FSM state enum, default outstanding-transaction limit.
package guvm_mem_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/guvm_id_fifo.sv
// rtl/guvm_id_fifo.sv - in-order FIFO of requester IDs awaiting a memory response
// Ports: clk_i/rst_i clock and sync active-high reset; push_i/push_id_i enqueue an ID;
//        pop_i dequeues the head; full_o/empty_o status; head_o oldest ID.
module guvm_id_fifo
    import guvm_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  req_id_e push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_e head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    req_id_e        r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (r_count == CW'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign head_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    // Storage carries no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/guvm_mem_arbiter.sv
// rtl/guvm_mem_arbiter.sv - round-robin arbiter of instruction and data ports onto one memory port
// Ports: clk_i/rst_i clock and sync active-high reset;
//        instr_* core fetch port (req/gnt/addr/rvalid/rdata);
//        data_*  core load/store port (req/gnt/we/be/addr/wdata/rvalid/rdata);
//        mem_*   shared memory port (req/gnt/we/be/addr/wdata/rvalid/rdata);
//        err_o   sticky flag for a memory response with nothing outstanding.
module guvm_mem_arbiter
    import guvm_mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    arb_state_e r_state;
    req_id_e    r_hold_id;
    req_id_e    r_last_id;
    logic       r_err;

    req_id_e    w_win_id;
    logic       w_win_req;
    logic       w_fire;
    logic       w_full;
    logic       w_empty;
    req_id_e    w_head_id;
    logic       w_resp;

    // HOLD keeps the stalled winner; otherwise the port not served last wins a tie.
    always_comb begin
        w_win_id = REQ_DATA;
        if (r_state == ST_HOLD) begin
            w_win_id = r_hold_id;
        end else if (instr_req_i && data_req_i) begin
            if (r_last_id == REQ_DATA) begin
                w_win_id = REQ_INSTR;
            end else begin
                w_win_id = REQ_DATA;
            end
        end else if (instr_req_i) begin
            w_win_id = REQ_INSTR;
        end
    end

    assign w_win_req = (w_win_id == REQ_DATA) ? data_req_i : instr_req_i;

    // Full uses the registered count, so a same-cycle pop never frees a slot early.
    assign mem_req_o = !rst_i && w_win_req && !w_full;
    assign w_fire    = mem_req_o && mem_gnt_i;

    // Forwarded fields are zero when no request is presented.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            if (w_win_id == REQ_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign instr_gnt_o = w_fire && (w_win_id == REQ_INSTR);
    assign data_gnt_o  = w_fire && (w_win_id == REQ_DATA);

    guvm_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (w_fire),
        .push_id_i(w_win_id),
        .pop_i    (mem_rvalid_i),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .head_o   (w_head_id)
    );

    assign w_resp         = !rst_i && mem_rvalid_i && !w_empty;
    assign instr_rvalid_o = w_resp && (w_head_id == REQ_INSTR);
    assign data_rvalid_o  = w_resp && (w_head_id == REQ_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = r_err;

    // Reset points the round-robin at instr as last served, so data wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_ARB;
            r_hold_id <= REQ_DATA;
            r_last_id <= REQ_INSTR;
            r_err     <= 1'b0;
        end else begin
            if (w_fire) begin
                r_last_id <= w_win_id;
            end
            if (mem_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_ARB: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        r_state   <= ST_HOLD;
                        r_hold_id <= w_win_id;
                    end
                end
                ST_HOLD: begin
                    if (w_fire) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: doc/guvm_mem_arbiter.md
GUVM_MEM_ARBITER -- requirements
Module: guvm_mem_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, maximum number of granted transactions still awaiting rvalid.
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 instr_req_i  in  1  core instruction-fetch request.
REQ-005 instr_gnt_o  out  1  fetch request accepted this cycle.
REQ-006 instr_addr_i  in  32  fetch address, stable while instr_req_i high and not granted.
REQ-007 instr_rvalid_o  out  1  fetch read data valid.
REQ-008 instr_rdata_o  out  32  fetch read data.
REQ-009 data_req_i  in  1  core load/store request.
REQ-010 data_gnt_o  out  1  load/store accepted this cycle.
REQ-011 data_we_i  in  1  1 = store, 0 = load.
REQ-012 data_be_i  in  4  byte enables.
REQ-013 data_addr_i  in  32  load/store address.
REQ-014 data_wdata_i  in  32  store data.
REQ-015 data_rvalid_o  out  1  load/store response valid; stores also get one.
REQ-016 data_rdata_o  out  32  load data.
REQ-017 mem_req_o  out  1  shared memory request.
REQ-018 mem_gnt_i  in  1  memory accepted request.
REQ-019 mem_we_o  out  1  forwarded write enable; 0 for fetches.
REQ-020 mem_be_o  out  4  forwarded byte enables; 4'hF for fetches.
REQ-021 mem_addr_o  out  32  forwarded address.
REQ-022 mem_wdata_o  out  32  forwarded write data; 0 for fetches.
REQ-023 mem_rvalid_i  in  1  memory response valid, at least one cycle after its gnt.
REQ-024 mem_rdata_i  in  32  memory read data.
REQ-025 err_o  out  1  sticky: mem_rvalid_i seen with no outstanding transaction.

Function
REQ-026 FSM states ARB and HOLD. In ARB the winner is chosen combinationally. In HOLD the winner is locked.
REQ-027 In ARB, single requester wins. If both request, the requester not served by the last grant wins (round-robin); the pointer updates only on mem_req_o && mem_gnt_i.
REQ-028 mem_req_o = winner request && outstanding count < MAX_OUTSTANDING. Mux outputs carry winner's fields the same cycle (zero latency).
REQ-029 ARB->HOLD when mem_req_o && !mem_gnt_i. HOLD->ARB on mem_gnt_i. A request in HOLD is never withdrawn or switched, even if the other port requests.
REQ-030 Winner gnt_o = mem_req_o && mem_gnt_i. The loser's gnt_o is 0.
REQ-031 Each grant pushes the winner ID into an in-order ID FIFO of depth MAX_OUTSTANDING. Each mem_req_o high cycle with the FIFO full is forbidden: mem_req_o is held 0.
REQ-032 Full FIFO: no request is issued even if a pop occurs the same cycle. The request is issued the next cycle.
REQ-033 mem_rvalid_i pops the head ID. The matching port's rvalid_o pulses for 1 cycle. Both rdata_o ports equal mem_rdata_i at all times.
REQ-034 Simultaneous push and pop with the FIFO not full: both take effect and the count is unchanged.
REQ-035 mem_rvalid_i with the FIFO empty: no rvalid_o, FIFO unchanged, err_o set next cycle.

Reset
REQ-036 Reset state: FSM=ARB, FIFO empty, count 0, round-robin pointer favours data, err_o=0. All gnt_o, rvalid_o and mem_req_o are 0 while rst_i is high.
REQ-037 Reset mid-operation discards outstanding IDs. Later stray rvalids set err_o.

Structure
REQ-038 Package guvm_mem_pkg holds: requester enum (REQ_INSTR, REQ_DATA), FSM state enum, default MAX_OUTSTANDING.
REQ-039 The ID FIFO is sub-module guvm_id_fifo (push, pop, full, empty, head), with a log2-sized count.

Verification
REQ-040 Instr-only fetch 0x80 with gnt same cycle, rvalid 2 cycles later with 0x13 -> instr_gnt_o 1 cycle, instr_rvalid_o 1 cycle with 0x13, data ports idle.
REQ-041 Both request every cycle, mem_gnt_i=1 -> grants alternate data, instr, data, instr. Responses are routed in the same order.
REQ-042 Data store 0x100/0xDEADBEEF/be 4'hF with mem_gnt_i low 3 cycles while instr requests -> mem outputs stay the data fields for all 4 cycles, then data_gnt_o.
REQ-043 Two grants with no rvalid (FIFO full) -> mem_req_o 0 until the first rvalid, then reissued next cycle.
REQ-044 mem_rvalid_i pulsed after reset with no request -> err_o 1 and sticky, no rvalid_o.
REQ-045 rst_i asserted with 1 outstanding -> all outputs 0 next cycle. The late rvalid sets err_o.
